// File: rtl/conv_pkg.sv
// Shared operand types and default sizing for the conv core datapath.
package conv_pkg;
   localparam int FEED_IFM_WIDTH = 80;
   localparam int FEED_WGT_WIDTH = 24;
   localparam int FEED_DEPTH     = 4;

   typedef logic [FEED_IFM_WIDTH-1:0] ifm_t;
   typedef logic [FEED_WGT_WIDTH-1:0] wgt_t;
endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO with valid/ready push side and a registered head word
// that is loaded only when a pop request finds data available.
module feeder_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push_valid,
   input  logic [WIDTH-1:0]           push_data,
   output logic                       push_ready,
   input  logic                       pop_req,
   output logic                       popped,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push;

   // Pointers carry one extra bit so full and empty are distinguishable.
   assign level      = wr_ptr - rd_ptr;
   assign push_ready = (level != (AW+1)'(DEPTH));
   assign push       = push_valid && push_ready;
   assign popped     = pop_req && (level != '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         head   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (popped) begin
            rd_ptr <= rd_ptr + 1'b1;
            head   <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   // NOTE: storage has no reset; resetting the pointers already makes every entry invalid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/conv_feeder.sv
// Operand feeder: two independent FIFOs answering the conv core's read strobes,
// plus per-channel sticky underflow flags and served-word counters.
module conv_feeder import conv_pkg::*; #(
   parameter int IFM_WIDTH = FEED_IFM_WIDTH,
   parameter int WGT_WIDTH = FEED_WGT_WIDTH,
   parameter int DEPTH     = FEED_DEPTH,
   parameter int CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     start_conv,
   input  logic                     s_ifm_valid,
   output logic                     s_ifm_ready,
   input  logic [IFM_WIDTH-1:0]     s_ifm_data,
   input  logic                     s_wgt_valid,
   output logic                     s_wgt_ready,
   input  logic [WGT_WIDTH-1:0]     s_wgt_data,
   input  logic                     ifm_read,
   input  logic                     wgt_read,
   output logic [IFM_WIDTH-1:0]     ifm_group,
   output logic [WGT_WIDTH-1:0]     wgt_group,
   output logic [$clog2(DEPTH):0]   ifm_level,
   output logic [$clog2(DEPTH):0]   wgt_level,
   output logic                     ifm_underflow,
   output logic                     wgt_underflow,
   output logic [CNT_WIDTH-1:0]     ifm_served,
   output logic [CNT_WIDTH-1:0]     wgt_served
);
   logic ifm_pop, wgt_pop;
   logic ifm_starved, wgt_starved;

   feeder_fifo #(.WIDTH(IFM_WIDTH), .DEPTH(DEPTH)) u_ifm_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .push_valid (s_ifm_valid),
      .push_data  (s_ifm_data),
      .push_ready (s_ifm_ready),
      .pop_req    (ifm_read),
      .popped     (ifm_pop),
      .head       (ifm_group),
      .level      (ifm_level)
   );

   feeder_fifo #(.WIDTH(WGT_WIDTH), .DEPTH(DEPTH)) u_wgt_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .push_valid (s_wgt_valid),
      .push_data  (s_wgt_data),
      .push_ready (s_wgt_ready),
      .pop_req    (wgt_read),
      .popped     (wgt_pop),
      .head       (wgt_group),
      .level      (wgt_level)
   );

   assign ifm_starved = ifm_read && (ifm_level == '0);
   assign wgt_starved = wgt_read && (wgt_level == '0);

   // start_conv clears, but an underflow or pop in the same cycle still counts.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ifm_underflow <= 1'b0;
         wgt_underflow <= 1'b0;
         ifm_served    <= '0;
         wgt_served    <= '0;
      end else if (start_conv) begin
         ifm_underflow <= ifm_starved;
         wgt_underflow <= wgt_starved;
         ifm_served    <= CNT_WIDTH'(ifm_pop);
         wgt_served    <= CNT_WIDTH'(wgt_pop);
      end else begin
         ifm_underflow <= ifm_underflow | ifm_starved;
         wgt_underflow <= wgt_underflow | wgt_starved;
         ifm_served    <= ifm_served + CNT_WIDTH'(ifm_pop);
         wgt_served    <= wgt_served + CNT_WIDTH'(wgt_pop);
      end
   end
endmodule
